// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer: channel count,
// select width, channel index type and packed-lane helper.
package demux_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef logic [SEL_W-1:0] ch_idx_t;

    // Low bit of channel ch's lane inside a packed NUM_CH*width bus.
    function automatic int unsigned lane_lo(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry registered output slot: load wins over drain, data holds while
// the slot waits and keeps its stale value after being drained.
module demux_out_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Slot occupancy: set on load, cleared only by a handshake or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end else if (r_valid & i_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Slot payload: captured on load, otherwise held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= {WIDTH{1'b0}};
        end else if (i_load) begin
            r_data <= i_data;
        end else begin
            r_data <= r_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/demux_1cross4_stream.sv
// 1-to-4 stream demultiplexer: routes each accepted word to a registered slot
// on the selected channel; words for disabled channels are counted and dropped.
module demux_1cross4_stream
    import demux_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DROP_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [1:0]            in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            ch_en,
    output logic [4*WIDTH-1:0]    out_data,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
    output logic [DROP_W-1:0]     drop_cnt
);

    localparam int unsigned L0 = lane_lo(32'd0, WIDTH);
    localparam int unsigned L1 = lane_lo(32'd1, WIDTH);
    localparam int unsigned L2 = lane_lo(32'd2, WIDTH);
    localparam int unsigned L3 = lane_lo(32'd3, WIDTH);

    ch_idx_t             w_sel;
    logic [NUM_CH-1:0]   w_sel_onehot;
    logic [NUM_CH-1:0]   w_load;
    logic                w_sel_en;
    logic                w_acc;
    logic                w_drop;
    logic [DROP_W-1:0]   r_drop_cnt;

    assign w_sel = ch_idx_t'(in_sel);

    // Destination decode of the select field.
    always_comb begin
        w_sel_onehot = 4'b0000;
        case (w_sel)
            2'd0:    w_sel_onehot = 4'b0001;
            2'd1:    w_sel_onehot = 4'b0010;
            2'd2:    w_sel_onehot = 4'b0100;
            2'd3:    w_sel_onehot = 4'b1000;
            default: w_sel_onehot = 4'b0000;
        endcase
    end

    // Only the selected channel can stall the producer; a disabled channel
    // always accepts so that its words drain into the drop counter.
    assign w_sel_en = ch_en[w_sel];
    assign in_ready = ~w_sel_en | ~out_valid[w_sel] | out_ready[w_sel];
    assign w_acc    = in_valid & in_ready;
    assign w_load   = {NUM_CH{w_acc}} & w_sel_onehot & ch_en;
    assign w_drop   = w_acc & ~w_sel_en;

    demux_out_slot #(.WIDTH(WIDTH)) m0 (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load[0]),
        .i_data  (in_data),
        .i_ready (out_ready[0]),
        .o_valid (out_valid[0]),
        .o_data  (out_data[L0 +: WIDTH])
    );

    demux_out_slot #(.WIDTH(WIDTH)) m1 (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load[1]),
        .i_data  (in_data),
        .i_ready (out_ready[1]),
        .o_valid (out_valid[1]),
        .o_data  (out_data[L1 +: WIDTH])
    );

    demux_out_slot #(.WIDTH(WIDTH)) m2 (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load[2]),
        .i_data  (in_data),
        .i_ready (out_ready[2]),
        .o_valid (out_valid[2]),
        .o_data  (out_data[L2 +: WIDTH])
    );

    demux_out_slot #(.WIDTH(WIDTH)) m3 (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load[3]),
        .i_data  (in_data),
        .i_ready (out_ready[3]),
        .o_valid (out_valid[3]),
        .o_data  (out_data[L3 +: WIDTH])
    );

    // Saturating drop counter; it sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= {DROP_W{1'b0}};
        end else if (w_drop && (r_drop_cnt != {DROP_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + {{(DROP_W-1){1'b0}}, 1'b1};
        end else begin
            r_drop_cnt <= r_drop_cnt;
        end
    end

    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_demux_1cross4_stream.sv
// Directed bench for demux_1cross4_stream: routing, backpressure, streaming,
// enable change, saturating drops and asynchronous reset.
module tb_demux_1cross4_stream;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ch_en;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [7:0]  drop_cnt;

    int n_pass;
    int n_total;

    demux_1cross4_stream #(.WIDTH(8), .DROP_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ch_en     (ch_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] lane(input int n);
        return out_data[n*8 +: 8];
    endfunction

    // Drive one word at the falling edge and let it be taken at the next rising edge.
    task automatic send(input logic [7:0] d, input logic [1:0] s, input logic exp_rdy, input string tag);
        @(negedge clk);
        in_data  = d;
        in_sel   = s;
        in_valid = 1'b1;
        #1;
        check(tag, {31'd0, in_ready}, {31'd0, exp_rdy});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        in_data   = 8'h00;
        in_sel    = 2'd0;
        in_valid  = 1'b0;
        ch_en     = 4'b1111;
        out_ready = 4'b0000;

        #12;
        check("rst_valid", {28'd0, out_valid}, 32'h0);
        check("rst_data", out_data, 32'h0);
        check("rst_drop", {24'd0, drop_cnt}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Routing: one word per channel, nobody consumes.
        for (int n = 0; n < 4; n++) begin
            send(8'hA0 + 8'(n), 2'(n), 1'b1, "route_rdy");
        end
        check("route_valid", {28'd0, out_valid}, 32'hF);
        check("route_data", out_data, 32'hA3A2A1A0);

        // Drain channel 1 only.
        @(negedge clk);
        out_ready = 4'b0010;
        @(posedge clk);
        #1;
        out_ready = 4'b0000;
        check("drain1_valid", {28'd0, out_valid}, 32'hD);

        // Backpressure on full channel 2, then an empty channel accepts.
        send(8'hBB, 2'd2, 1'b0, "bp_rdy_full");
        check("bp_lane2_held", {24'd0, lane(2)}, 32'hA2);
        check("bp_valid_held", {28'd0, out_valid}, 32'hD);
        send(8'hC1, 2'd1, 1'b1, "bp_rdy_empty");
        check("bp_valid", {28'd0, out_valid}, 32'hF);
        check("bp_data", out_data, 32'hA3A2C1A0);

        // Streaming: 16 back-to-back words into channel 3 with its consumer ready.
        @(negedge clk);
        out_ready = 4'b1000;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_data  = 8'h10 + 8'(i);
            in_sel   = 2'd3;
            in_valid = 1'b1;
            #1;
            check("stream_rdy", {31'd0, in_ready}, 32'h1);
            @(posedge clk);
            #1;
            check("stream_lane3", {24'd0, lane(3)}, {24'd0, 8'h10 + 8'(i)});
            check("stream_valid3", {31'd0, out_valid[3]}, 32'h1);
        end
        idle_cycle();
        check("stream_drained", {28'd0, out_valid}, 32'h7);
        check("stream_stale", {24'd0, lane(3)}, 32'h1F);
        out_ready = 4'b0000;

        // Enable change while full: the held word is still delivered.
        @(negedge clk);
        out_ready = 4'b0010;
        @(posedge clk);
        #1;
        out_ready = 4'b0000;
        send(8'h55, 2'd1, 1'b1, "en_load_rdy");
        check("en_loaded", {23'd0, out_valid[1], lane(1)}, 32'h155);
        @(negedge clk);
        ch_en = 4'b1101;
        @(posedge clk);
        #1;
        check("en_still_full", {23'd0, out_valid[1], lane(1)}, 32'h155);
        @(negedge clk);
        out_ready = 4'b0010;
        #1;
        check("en_deliver", {23'd0, out_valid[1], lane(1)}, 32'h155);
        @(posedge clk);
        #1;
        out_ready = 4'b0000;
        check("en_drained", {23'd0, out_valid[1], lane(1)}, 32'h055);
        send(8'h66, 2'd1, 1'b1, "en_drop_rdy");
        check("en_drop_cnt", {24'd0, drop_cnt}, 32'h1);
        check("en_no_load", {23'd0, out_valid[1], lane(1)}, 32'h055);

        // Drops: 300 words to disabled channel 0; counter saturates at 255.
        @(negedge clk);
        ch_en = 4'b1110;
        for (int i = 0; i < 300; i++) begin
            send(8'(i), 2'd0, 1'b1, "drop_rdy");
            check("drop_cnt", {24'd0, drop_cnt}, (i + 2 > 255) ? 32'd255 : 32'(i + 2));
        end
        check("drop_slot0", {23'd0, out_valid[0], lane(0)}, 32'h1A0);
        check("drop_valid", {28'd0, out_valid}, 32'h5);

        // Fill every slot, then reset asynchronously in mid-cycle.
        @(negedge clk);
        ch_en = 4'b1111;
        send(8'hD1, 2'd1, 1'b1, "fill1_rdy");
        send(8'hD3, 2'd3, 1'b1, "fill3_rdy");
        check("fill_valid", {28'd0, out_valid}, 32'hF);
        check("fill_data", out_data, 32'hD3A2D1A0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", {28'd0, out_valid}, 32'h0);
        check("async_rst_drop", {24'd0, drop_cnt}, 32'h0);
        check("async_rst_data", out_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/demux_1cross4_stream.md
Name: demux_1cross4_stream

Overview:
- 1-to-4 stream demultiplexer; the distribution-side counterpart of the 4x1 mux tree.
- Accepts one WIDTH-bit word per handshake with a 2-bit destination select, and routes it into a registered one-entry slot on the selected output channel.
- Each output channel has its own valid/ready handshake.
- A per-channel enable mask discards words addressed to disabled channels; a saturating drop counter records each discard.
- Sits between a single producer and four independent consumers.

Parameters:
- WIDTH, 8, data word width in bits.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  input word.
- in_sel  input  2  destination channel for in_data (0..3).
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can take the word this cycle.
- ch_en  input  4  per-channel enable; bit n=0 means words for channel n are dropped.
- out_data  output  4*WIDTH  channel n word at bits [n*WIDTH +: WIDTH].
- out_valid  output  4  channel n slot holds a word.
- out_ready  input  4  consumer n takes the word this cycle.
- drop_cnt  output  DROP_W  number of dropped words, saturating.

Behaviour:
- Reset (async, rst=1): out_valid=4'b0000, out_data all zeros, drop_cnt=0. Reset mid-transfer discards every slot content.
- in_ready is combinational:
  - in_ready = !ch_en[in_sel] | !out_valid[in_sel] | out_ready[in_sel].
  - It depends only on the selected channel; other channels never stall the input.
- Accept: acc = in_valid & in_ready.
- Per channel n, on a rising edge:
  - load_n = acc & (in_sel==n) & ch_en[n].
  - If load_n: out_data[n] <= in_data, out_valid[n] <= 1 (load wins over drain, so simultaneous drain+load gives back-to-back throughput).
  - Else if out_valid[n] & out_ready[n]: out_valid[n] <= 0, out_data[n] holds its value.
  - Otherwise hold.
- Latency: an accepted word appears on out_data/out_valid of its channel one cycle after the accept edge.
- Throughput: 1 word/cycle whenever the destination consumer keeps out_ready=1.
- Ordering: words to the same channel are delivered in acceptance order. There is no ordering guarantee across channels.
- Drop path:
  - acc & !ch_en[in_sel] → word discarded, no slot changes.
  - drop_cnt increments by 1 per drop and saturates at 2^DROP_W-1 (no wrap).
- Enable change while a slot is full: the slot content is still delivered normally. ch_en only gates new loads.
- out_data is stable while out_valid[n]=1 and out_ready[n]=0.
- A cleared slot keeps its stale data; consumers must qualify out_data with out_valid.
- The block never deasserts out_valid without a handshake, except on reset.
- The block has no internal requirement on in_sel/in_data while in_valid=0.

Decomposition:
- Shared package demux_pkg:
  - NUM_CH=4 and SEL_W=2.
  - The channel index type.
  - The lane-slice helper for packed out_data.
- Sub-module demux_out_slot: one-entry registered slot with load, drain and data hold, parameterised by WIDTH.
  - Instantiated 4 times (m0..m3), structurally, in the same style as the mux tree.
  - The top level holds the select decode, in_ready logic and drop counter.

Test Plan:
- Reset: assert rst mid-cycle with all four slots full → out_valid=0000 and drop_cnt=0 immediately, without waiting for a clock edge.
- Routing: ch_en=1111, out_ready=0000, send 8'hA0,A1,A2,A3 with sel 0,1,2,3 → out_valid=1111, lane n = 8'hAn, in_ready=1 for each accept.
- Backpressure: channel 2 full, out_ready[2]=0, in_sel=2 → in_ready=0. Switch in_sel=1 (slot 1 empty) → in_ready=1 and the word lands in lane 1 only.
- Streaming: out_ready[3]=1, 16 consecutive words 0x10..0x1F to sel=3 → 16 accepts in 16 cycles; out_data[3] shows 0x10..0x1F in order, each one cycle after its accept.
- Drops: ch_en=1110, send 300 words with sel=0 → no change in out_valid[0], in_ready stays 1, drop_cnt=255 (saturated).
- Enable change while full: load 8'h55 on channel 1, clear ch_en[1], then set out_ready[1]=1 → 8'h55 is still delivered; a subsequent sel=1 word increments drop_cnt by 1.
